// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-state core.
package snake_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_PLACE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_t;

   localparam int         GRID_DIM    = 16;
   localparam int         NUM_SEG     = 16;
   localparam logic [3:0] GRID_LAST   = 4'(GRID_DIM - 1);
   localparam logic [7:0] INIT_HEAD   = 8'h84;
   localparam logic [7:0] INIT_BODY_1 = 8'h83;
   localparam logic [7:0] INIT_BODY_2 = 8'h82;
   localparam logic [3:0] INIT_LEN    = 4'd3;
   localparam logic [7:0] LFSR_TAPS   = 8'hB8;

   function automatic logic [7:0] init_body(input logic [3:0] idx);
      logic [7:0] v;
      case (idx)
         4'd0:    v = INIT_HEAD;
         4'd1:    v = INIT_BODY_1;
         4'd2:    v = INIT_BODY_2;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic dir_t dir_reverse(input dir_t d);
      dir_t r;
      case (d)
         DIR_RIGHT: r = DIR_LEFT;
         DIR_LEFT:  r = DIR_RIGHT;
         DIR_UP:    r = DIR_DOWN;
         DIR_DOWN:  r = DIR_UP;
         default:   r = DIR_RIGHT;
      endcase
      return r;
   endfunction

   // x^8+x^6+x^5+x^4+1 Fibonacci step, shifting towards the MSB
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 8-bit maximal-length Fibonacci LFSR used as the food candidate source.
module snake_lfsr
   import snake_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [7:0] i_seed,
   input  logic       i_advance,
   output logic [7:0] o_q
);

   logic [7:0] r_q;

   // LFSR state: reload, step, or hold
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= SEED;
      end else if (i_load) begin
         r_q <= i_seed;
      end else if (i_advance) begin
         r_q <= lfsr_next(r_q);
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/snake_engine.sv
// Snake game-state core: body, length, food placement and win/lose/init status,
// all held in registers feeding the renderer directly.
module snake_engine
   import snake_pkg::*;
#(
   parameter int         MAX_LEN   = 15,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         Tick,
   input  logic         Start,
   input  logic         BtnU,
   input  logic         BtnD,
   input  logic         BtnL,
   input  logic         BtnR,
   output logic         Qi,
   output logic         Qw,
   output logic         Ql,
   output logic         Qc,
   output logic [7:0]   Food,
   output logic [3:0]   Length,
   output logic [127:0] Locations_Flat
);

   state_t               r_state, w_state_next;
   dir_t                 r_heading, r_pending, w_heading_next, w_pending_next;
   dir_t                 w_btn_dir, w_ref_dir;
   logic [7:0]           r_body [NUM_SEG];
   logic [3:0]           r_len;
   logic [7:0]           r_food;
   logic                 r_qi, r_qw, r_ql, r_qc;
   logic [7:0]           w_lfsr_q, w_cmp, w_next_head;
   logic [3:0]           w_row, w_col, w_len_inc;
   logic [NUM_SEG-1:0]   w_eq, w_len_mask, w_self_mask;
   logic                 w_btn_valid, w_wall, w_eat, w_occupied, w_self_hit;
   logic                 w_load_init, w_shift, w_grow, w_accept, w_advance;

   snake_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .i_clk     (Clk),
      .i_rst_n   (Reset_n),
      .i_load    (1'b0),
      .i_seed    (LFSR_SEED),
      .i_advance (w_advance),
      .o_q       (w_lfsr_q)
   );

   // Same-cycle direction pulses resolve U > D > L > R
   always_comb begin
      w_btn_valid = 1'b1;
      w_btn_dir   = DIR_RIGHT;
      if (BtnU) begin
         w_btn_dir = DIR_UP;
      end else if (BtnD) begin
         w_btn_dir = DIR_DOWN;
      end else if (BtnL) begin
         w_btn_dir = DIR_LEFT;
      end else if (BtnR) begin
         w_btn_dir = DIR_RIGHT;
      end else begin
         w_btn_valid = 1'b0;
      end
   end

   assign w_row = r_body[0][7:4];
   assign w_col = r_body[0][3:0];

   // Next head cell and wall detection from the pending direction
   always_comb begin
      w_wall      = 1'b0;
      w_next_head = r_body[0];
      case (r_pending)
         DIR_UP: begin
            w_wall      = (w_row == 4'd0);
            w_next_head = {w_row - 4'd1, w_col};
         end
         DIR_DOWN: begin
            w_wall      = (w_row == GRID_LAST);
            w_next_head = {w_row + 4'd1, w_col};
         end
         DIR_LEFT: begin
            w_wall      = (w_col == 4'd0);
            w_next_head = {w_row, w_col - 4'd1};
         end
         DIR_RIGHT: begin
            w_wall      = (w_col == GRID_LAST);
            w_next_head = {w_row, w_col + 4'd1};
         end
         default: begin
            w_wall      = 1'b0;
            w_next_head = r_body[0];
         end
      endcase
   end

   // One comparator bank serves both the food-free check and the self-hit check
   assign w_cmp = (r_state == ST_PLACE) ? w_lfsr_q : w_next_head;

   // Per-segment equality plus length masks (tail excluded for self-hit)
   always_comb begin
      w_eq        = '0;
      w_len_mask  = '0;
      w_self_mask = '0;
      for (int i = 0; i < NUM_SEG; i++) begin
         w_eq[i]        = (r_body[i] == w_cmp);
         w_len_mask[i]  = (5'(i) < {1'b0, r_len});
         w_self_mask[i] = ((5'(i) + 5'd1) < {1'b0, r_len});
      end
   end

   assign w_occupied = |(w_eq & w_len_mask);
   assign w_self_hit = |(w_eq & w_self_mask);
   assign w_eat      = (w_next_head == r_food);
   assign w_len_inc  = r_len + 4'd1;
   // On a tick edge the heading becomes the pending direction, so judge reversal against that
   assign w_ref_dir  = Tick ? r_pending : r_heading;

   // Game FSM next-state and datapath control
   always_comb begin
      w_state_next   = r_state;
      w_heading_next = r_heading;
      w_pending_next = r_pending;
      w_load_init    = 1'b0;
      w_shift        = 1'b0;
      w_grow         = 1'b0;
      w_accept       = 1'b0;
      w_advance      = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_pending_next = DIR_RIGHT;
            if (Start) begin
               w_state_next = ST_PLACE;
            end else begin
               w_state_next = ST_INIT;
            end
         end
         ST_PLACE: begin
            w_advance = 1'b1;
            if (!w_occupied) begin
               w_accept     = 1'b1;
               w_state_next = ST_PLAY;
            end else begin
               w_state_next = ST_PLACE;
            end
         end
         ST_PLAY: begin
            if (w_btn_valid && (w_btn_dir != dir_reverse(w_ref_dir))) begin
               w_pending_next = w_btn_dir;
            end else begin
               w_pending_next = r_pending;
            end
            if (Tick) begin
               w_heading_next = r_pending;
               if (w_wall || w_self_hit) begin
                  w_state_next = ST_LOSE;
               end else if (w_eat) begin
                  w_shift = 1'b1;
                  w_grow  = 1'b1;
                  if (w_len_inc == 4'(MAX_LEN)) begin
                     w_state_next = ST_WIN;
                  end else begin
                     w_state_next = ST_PLACE;
                  end
               end else begin
                  w_shift = 1'b1;
               end
            end else begin
               w_heading_next = r_heading;
            end
         end
         ST_WIN, ST_LOSE: begin
            if (Start) begin
               w_load_init    = 1'b1;
               w_heading_next = DIR_RIGHT;
               w_pending_next = DIR_RIGHT;
               w_state_next   = ST_INIT;
            end else begin
               w_state_next = r_state;
            end
         end
         default: begin
            w_state_next = ST_INIT;
         end
      endcase
   end

   // Game state, body, length, food and registered status outputs
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= ST_INIT;
         r_heading <= DIR_RIGHT;
         r_pending <= DIR_RIGHT;
         for (int i = 0; i < NUM_SEG; i++) begin
            r_body[i] <= init_body(4'(i));
         end
         r_len  <= INIT_LEN;
         r_food <= 8'h00;
         r_qi   <= 1'b1;
         r_qw   <= 1'b0;
         r_ql   <= 1'b0;
         r_qc   <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_heading <= w_heading_next;
         r_pending <= w_pending_next;
         if (w_load_init) begin
            for (int i = 0; i < NUM_SEG; i++) begin
               r_body[i] <= init_body(4'(i));
            end
            r_len  <= INIT_LEN;
            r_food <= 8'h00;
         end else begin
            if (w_shift) begin
               r_body[0] <= w_next_head;
               for (int i = 1; i < NUM_SEG; i++) begin
                  r_body[i] <= r_body[i-1];
               end
            end
            if (w_grow) begin
               r_len <= w_len_inc;
            end
            if (w_accept) begin
               r_food <= w_cmp;
            end
         end
         r_qi <= (w_state_next == ST_INIT);
         r_qw <= (w_state_next == ST_WIN);
         r_ql <= (w_state_next == ST_LOSE);
         r_qc <= w_accept;
      end
   end

   assign Qi     = r_qi;
   assign Qw     = r_qw;
   assign Ql     = r_ql;
   assign Qc     = r_qc;
   assign Food   = r_food;
   assign Length = r_len;

   for (genvar g = 0; g < NUM_SEG; g++) begin : g_flat
      assign Locations_Flat[127-8*g -: 8] = r_body[g];
   end

endmodule
